// File: rtl/axis_pkt_capture_fifo.sv
// Store-and-forward AXI4-Stream packet buffer feeding a pcap dumper.
// Only whole packets are forwarded; overflowing or oversized packets are dropped whole.
module axis_pkt_capture_fifo #(
    parameter int AXIS_WIDTH    = 64,
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXIS_WIDTH-1:0]   s_tdata,
    input  logic [AXIS_WIDTH/8-1:0] s_tstrb,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [AXIS_WIDTH-1:0]   m_tdata,
    output logic [AXIS_WIDTH/8-1:0] m_tstrb,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [DEPTH_LOG2:0]     pkts_stored,
    output logic [15:0]             pkt_count,
    output logic [15:0]             drop_count
);

    localparam int SW    = AXIS_WIDTH / 8;
    localparam int EW    = AXIS_WIDTH + SW + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = $clog2(MAX_PKT_BEATS + 1);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   PS_ONE  = 1;
    localparam logic [BW-1:0]         BI_ONE  = 1;
    localparam logic [BW-1:0]         MAX_B   = BW'(MAX_PKT_BEATS);

    logic [EW-1:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_spec;
    logic [DEPTH_LOG2-1:0] r_wr_commit;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [BW-1:0]         r_beat_idx;
    logic                  r_drop;
    logic                  r_resync;
    logic [15:0]           r_pkt_count;
    logic [15:0]           r_drop_count;
    logic [DEPTH_LOG2:0]   r_pkts_stored;
    logic [AXIS_WIDTH-1:0] r_m_tdata;
    logic [SW-1:0]         r_m_tstrb;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;

    logic [DEPTH_LOG2-1:0] w_spec_nxt;
    logic                  w_full;
    logic                  w_cap_ok;
    logic                  w_wr;
    logic                  w_commit;
    logic                  w_drop_evt;
    logic                  w_drop_end;
    logic                  w_load;
    logic                  w_done_last;
    logic [EW-1:0]         w_rd_entry;

    assign w_spec_nxt  = r_wr_spec + PTR_ONE;
    assign w_full      = (w_spec_nxt == r_rd_ptr);
    assign w_cap_ok    = (r_beat_idx < MAX_B);
    assign w_wr        = s_tvalid & ~r_resync & ~r_drop & ~w_full & w_cap_ok;
    assign w_commit    = w_wr & s_tlast;
    assign w_drop_evt  = s_tvalid & ~r_resync & ~w_wr;
    assign w_drop_end  = w_drop_evt & s_tlast;
    assign w_load      = (r_rd_ptr != r_wr_commit) & (~r_m_tvalid | m_tready);
    assign w_done_last = r_m_tvalid & m_tready & r_m_tlast;
    assign w_rd_entry  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_spec] <= {s_tlast, s_tstrb, s_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_spec    <= '0;
            r_wr_commit  <= '0;
            r_beat_idx   <= '0;
            r_drop       <= 1'b0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            // Reset mid-packet: the packet's tail must be skipped, not stored as a new packet
            r_resync     <= (r_beat_idx != '0) | r_drop | (s_tvalid & ~s_tlast);
        end else begin
            if (w_wr) begin
                r_wr_spec  <= w_spec_nxt;
                r_beat_idx <= r_beat_idx + BI_ONE;
            end
            if (w_commit) begin
                r_wr_commit <= w_spec_nxt;
                r_pkt_count <= r_pkt_count + 16'd1;
                r_beat_idx  <= '0;
            end
            if (w_drop_evt) begin
                r_wr_spec  <= r_wr_commit;
                r_drop     <= ~s_tlast;
                r_beat_idx <= '0;
            end
            if (w_drop_end) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (r_resync & s_tvalid & s_tlast) begin
                r_resync <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_m_tstrb     <= '0;
            r_m_tlast     <= 1'b0;
            r_pkts_stored <= '0;
        end else begin
            if (w_load) begin
                {r_m_tlast, r_m_tstrb, r_m_tdata} <= w_rd_entry;
                r_m_tvalid <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_commit & ~w_done_last) begin
                r_pkts_stored <= r_pkts_stored + PS_ONE;
            end else if (~w_commit & w_done_last) begin
                r_pkts_stored <= r_pkts_stored - PS_ONE;
            end
        end
    end

    assign s_tready    = 1'b1;
    assign m_tdata     = r_m_tdata;
    assign m_tstrb     = r_m_tstrb;
    assign m_tvalid    = r_m_tvalid;
    assign m_tlast     = r_m_tlast;
    assign pkts_stored = r_pkts_stored;
    assign pkt_count   = r_pkt_count;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_axis_pkt_capture_fifo.sv
// Directed bench for axis_pkt_capture_fifo: a 16-deep instance for the main
// scenarios and a second 16-deep instance with an 8-beat length cap.
module tb_axis_pkt_capture_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [4:0]  pkts_stored;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    logic [63:0] c_s_tdata;
    logic [7:0]  c_s_tstrb;
    logic        c_s_tvalid;
    logic        c_s_tlast;
    logic        c_s_tready;
    logic [63:0] c_m_tdata;
    logic [7:0]  c_m_tstrb;
    logic        c_m_tvalid;
    logic        c_m_tlast;
    logic        c_m_tready;
    logic [4:0]  c_pkts_stored;
    logic [15:0] c_pkt_count;
    logic [15:0] c_drop_count;

    axis_pkt_capture_fifo #(
        .AXIS_WIDTH(64), .DEPTH_LOG2(4), .MAX_PKT_BEATS(256)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready),
        .pkts_stored(pkts_stored), .pkt_count(pkt_count),
        .drop_count(drop_count)
    );

    axis_pkt_capture_fifo #(
        .AXIS_WIDTH(64), .DEPTH_LOG2(4), .MAX_PKT_BEATS(8)
    ) u_cap (
        .clk(clk), .rst(rst),
        .s_tdata(c_s_tdata), .s_tstrb(c_s_tstrb), .s_tvalid(c_s_tvalid),
        .s_tlast(c_s_tlast), .s_tready(c_s_tready),
        .m_tdata(c_m_tdata), .m_tstrb(c_m_tstrb), .m_tvalid(c_m_tvalid),
        .m_tlast(c_m_tlast), .m_tready(c_m_tready),
        .pkts_stored(c_pkts_stored), .pkt_count(c_pkt_count),
        .drop_count(c_drop_count)
    );

    int total = 0;
    int bad   = 0;

    logic        mon_en = 1'b0;
    logic [64:0] q[$];

    always @(negedge clk) begin
        if (mon_en && !rst && m_tvalid && m_tready)
            q.push_back({m_tlast, m_tdata});
    end

    function automatic logic [63:0] mk(input int base, input int i);
        return {16'hDEAD, base[15:0], i[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk(base, i);
            s_tstrb  = 8'hFF;
            s_tlast  = (i == n - 1);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic csend_pkt(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            c_s_tvalid = 1'b1;
            c_s_tdata  = mk(base, i);
            c_s_tstrb  = 8'hFF;
            c_s_tlast  = (i == n - 1);
            tick();
        end
        c_s_tvalid = 1'b0;
        c_s_tlast  = 1'b0;
    endtask

    initial begin
        int nerr;
        rst        = 1'b1;
        s_tdata    = '0;
        s_tstrb    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        c_s_tdata  = '0;
        c_s_tstrb  = '0;
        c_s_tvalid = 1'b0;
        c_s_tlast  = 1'b0;
        c_m_tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_tready", s_tready, 1);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_stored", pkts_stored, 0);
        chk("rst_pkts", pkt_count, 0);
        chk("rst_drops", drop_count, 0);

        // Single 3-beat packet, last strobe 0F
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk(1, i);
            s_tstrb  = (i == 2) ? 8'h0F : 8'hFF;
            s_tlast  = (i == 2);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("t1_lat_early", m_tvalid, 0);
        tick();
        chk("t1_first_valid", m_tvalid, 1);
        chk("t1_stored1", pkts_stored, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", m_tdata, mk(1, i));
            chk("t1_strb", m_tstrb, (i == 2) ? 8'h0F : 8'hFF);
            chk("t1_last", m_tlast, (i == 2));
            tick();
        end
        chk("t1_idle", m_tvalid, 0);
        chk("t1_stored0", pkts_stored, 0);
        chk("t1_pkts", pkt_count, 1);
        chk("t1_drops", drop_count, 0);

        // Back-pressure with two 4-beat packets
        m_tready = 1'b0;
        send_pkt(4, 2);
        send_pkt(4, 3);
        chk("t2_stored2", pkts_stored, 2);
        chk("t2_valid", m_tvalid, 1);
        chk("t2_head", m_tdata, mk(2, 0));
        repeat (3) tick();
        chk("t2_hold_data", m_tdata, mk(2, 0));
        chk("t2_hold_last", m_tlast, 0);
        chk("t2_hold_valid", m_tvalid, 1);
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_valid_run", m_tvalid, 1);
            chk("t2_data", m_tdata, mk((k < 4) ? 2 : 3, k % 4));
            chk("t2_last", m_tlast, (k % 4 == 3));
            tick();
        end
        chk("t2_idle", m_tvalid, 0);
        chk("t2_stored0", pkts_stored, 0);
        chk("t2_pkts", pkt_count, 3);

        // Overflow: 20 beats into 15 free slots
        m_tready = 1'b0;
        send_pkt(20, 4);
        repeat (2) tick();
        chk("t3_no_out", m_tvalid, 0);
        chk("t3_stored", pkts_stored, 0);
        chk("t3_drops", drop_count, 1);
        chk("t3_pkts", pkt_count, 3);
        m_tready = 1'b1;
        send_pkt(5, 5);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_valid", m_tvalid, 1);
            chk("t3_data", m_tdata, mk(5, k));
            chk("t3_last", m_tlast, (k == 4));
            tick();
        end
        chk("t3_idle", m_tvalid, 0);
        chk("t3_pkts_after", pkt_count, 4);
        chk("t3_drops_after", drop_count, 1);

        // Length cap of 8 beats
        csend_pkt(9, 6);
        repeat (3) tick();
        chk("t4_tready", c_s_tready, 1);
        chk("t4_no_out", c_m_tvalid, 0);
        chk("t4_drops", c_drop_count, 1);
        chk("t4_pkts0", c_pkt_count, 0);
        csend_pkt(8, 7);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("t4_valid", c_m_tvalid, 1);
            chk("t4_data", c_m_tdata, mk(7, k));
            chk("t4_last", c_m_tlast, (k == 7));
            tick();
        end
        chk("t4_pkts1", c_pkt_count, 1);
        chk("t4_drops_after", c_drop_count, 1);
        chk("t4_stored", c_pkts_stored, 0);

        // Full-rate stream of 100 two-beat packets
        q.delete();
        mon_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            for (int i = 0; i < 2; i++) begin
                s_tvalid = 1'b1;
                s_tdata  = mk(100 + p, i);
                s_tstrb  = 8'hFF;
                s_tlast  = (i == 1);
                tick();
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (6) tick();
        mon_en = 1'b0;
        chk("t5_count", q.size(), 200);
        nerr = 0;
        for (int k = 0; k < q.size() && k < 200; k++) begin
            if (q[k] !== {(k % 2 == 1), mk(100 + k / 2, k % 2)})
                nerr++;
        end
        chk("t5_order", nerr, 0);
        chk("t5_pkts", pkt_count, 104);
        chk("t5_drops", drop_count, 1);
        chk("t5_stored", pkts_stored, 0);

        // Reset mid-packet with one committed packet unread
        m_tready = 1'b0;
        send_pkt(3, 8);
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk(9, i);
            s_tstrb  = 8'hFF;
            s_tlast  = 1'b0;
            tick();
        end
        chk("t6_pre_valid", m_tvalid, 1);
        s_tvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid0", m_tvalid, 0);
        chk("t6_stored0", pkts_stored, 0);
        chk("t6_pkts0", pkt_count, 0);
        chk("t6_drops0", drop_count, 0);
        m_tready = 1'b1;
        q.delete();
        mon_en = 1'b1;
        for (int i = 2; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk(9, i);
            s_tstrb  = 8'hFF;
            s_tlast  = (i == 4);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (4) tick();
        chk("t6_tail_out", q.size(), 0);
        chk("t6_tail_drops", drop_count, 0);
        chk("t6_tail_pkts", pkt_count, 0);
        chk("t6_tail_stored", pkts_stored, 0);
        send_pkt(2, 10);
        repeat (4) tick();
        mon_en = 1'b0;
        chk("t6_clean_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("t6_clean_b0", q[0], {1'b0, mk(10, 0)});
            chk("t6_clean_b1", q[1], {1'b1, mk(10, 1)});
        end
        chk("t6_clean_pkts", pkt_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_capture_fifo.md
Name: axis_pkt_capture_fifo

Overview:
- Store-and-forward AXI4-Stream packet buffer that sits directly upstream of the pcap dumper in network test benches.
- Accepts a stream that can never be back-pressured, because s_tready is tied high.
- Holds only complete packets and forwards them to the dumper, with tstrb preserved per beat.
- Packets that overflow the buffer, or exceed a length cap, are dropped whole and counted, so the dumper never sees truncated or corrupted frames.

Parameters:
AXIS_WIDTH, 64, data width in bits; must be a multiple of 8.
DEPTH_LOG2, 9, log2 of buffer depth in beats; usable capacity is 2^DEPTH_LOG2 - 1 beats.
MAX_PKT_BEATS, 256, longest packet accepted, in beats; longer packets are dropped.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
s_tdata  in  AXIS_WIDTH  input beat data.
s_tstrb  in  AXIS_WIDTH/8  input byte strobes; stored verbatim.
s_tvalid  in  1  input beat valid.
s_tlast  in  1  input end of packet.
s_tready  out  1  constant 1.
m_tdata  out  AXIS_WIDTH  output beat data.
m_tstrb  out  AXIS_WIDTH/8  output byte strobes.
m_tvalid  out  1  output beat valid.
m_tlast  out  1  output end of packet.
m_tready  in  1  downstream ready.
pkts_stored  out  DEPTH_LOG2+1  complete packets committed but not fully read.
pkt_count  out  16  packets committed since reset; wraps.
drop_count  out  16  packets dropped since reset; wraps.

Behaviour:
- Storage: RAM of 2^DEPTH_LOG2 entries, each holding {tlast, tstrb, tdata}.
- Pointers: wr_spec (speculative write), wr_commit and rd_ptr, each DEPTH_LOG2 bits and wrapping modulo depth.
- Full: wr_spec+1 == rd_ptr. One slot is always kept empty.
- Write side, on each accepted beat (s_tvalid=1):
  - If not dropping, buffer not full, and beat_idx < MAX_PKT_BEATS: write at wr_spec, increment wr_spec and beat_idx.
  - Otherwise enter drop: wr_spec <= wr_commit and drop flag set. The offending beat is not written.
  - A tlast beat that is written: wr_commit <= wr_spec+1, pkt_count++, pkts_stored++, beat_idx <= 0.
  - A tlast beat while dropping, or one that itself triggers a drop: drop_count++, drop flag clear, beat_idx <= 0.
  - While the drop flag is set, every beat is discarded until tlast inclusive.
- Read side: the output register loads from rd_ptr whenever rd_ptr != wr_commit and (m_tvalid=0 or m_tready=1).
  - rd_ptr increments on each load.
  - m_tvalid/m_tdata/m_tstrb/m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Handshake completion: a beat completes when m_tvalid & m_tready.
  - When the completed beat has m_tlast=1, pkts_stored decrements.
  - Simultaneous commit and completion of a last beat leaves pkts_stored unchanged.
- Latency: tlast accepted on edge E means m_tvalid rises after edge E+1 and is visible in the cycle following E+1; i.e. 2 cycles from tlast acceptance to first output beat.
- Throughput: 1 beat/cycle when m_tready=1. Reads and writes proceed concurrently. Free space is evaluated against the current rd_ptr, so space freed by a read on the same edge is not usable until the next cycle.
- Output gating: only committed beats are ever read. A packet in progress is never output.
- Beat contents: tstrb is not interpreted; all-zero strobe beats are stored and forwarded unchanged.
- Reset: all pointers, beat_idx, drop flag and counters go to 0; m_tvalid=0; m_tdata, m_tstrb, m_tlast = 0; pkts_stored=0. Reset mid-packet discards partial and stored data without counting a drop.

Test Plan:
- Single packet: AXIS_WIDTH=64, DEPTH_LOG2=4. Send 3 beats (tstrb FF,FF,0F) with m_tready=1 -> first m_tvalid 2 cycles after the tlast beat; 3 identical beats out with m_tlast on beat 3; pkt_count=1, drop_count=0, pkts_stored returns to 0.
- Back-pressure: m_tready=0, send two 4-beat packets -> pkts_stored=2, m_tvalid=1 with the first beat held stable. Release m_tready -> 8 consecutive beats out, m_tlast on beats 4 and 8.
- Overflow: DEPTH_LOG2=4, m_tready=0, send a 20-beat packet -> nothing output, drop_count=1, pkts_stored=0. Then send a 5-beat packet with m_tready=1 -> it is output intact; pkt_count=1.
- Length cap: MAX_PKT_BEATS=8, send a 9-beat packet into an empty buffer -> dropped, drop_count=1. An 8-beat packet sent next passes; pkt_count=1.
- Full-rate stream: m_tready=1, 100 back-to-back 2-beat packets with s_tvalid=1 every cycle -> 200 beats out in order, drop_count=0, pkt_count=100.
- Reset mid-operation: assert rst for 1 cycle after beat 2 of a 5-beat packet, with one committed packet unread -> m_tvalid=0 the cycle after reset. The remaining 3 beats of the partial packet are also discarded: they are not written and drop_count stays 0. All counters read 0.
